// File: rtl/us_ip_pkg.sv
// Shared IP-layer constants and FSM encodings for the receive and transmit mode blocks.
package us_ip_pkg;

  localparam logic [7:0] IP_PROTO_ICMP = 8'h01;
  localparam logic [7:0] IP_PROTO_UDP  = 8'h11;

  typedef enum logic [3:0] {
    RX_IDLE = 4'b0001,
    RX_UDP  = 4'b0010,
    RX_ICMP = 4'b0100,
    RX_DROP = 4'b1000
  } rx_state_e;

endpackage

// File: rtl/us_axis_reg_slice.sv
// Single-entry AXI-Stream register stage: one cycle of latency, full throughput when drained.
module us_axis_reg_slice (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_s_tdata,
  input  logic [7:0]  i_s_tkeep,
  input  logic        i_s_tlast,
  input  logic        i_s_tvalid,
  output logic        o_s_tready,
  output logic [63:0] o_m_tdata,
  output logic [7:0]  o_m_tkeep,
  output logic        o_m_tlast,
  output logic        o_m_tvalid,
  input  logic        i_m_tready
);

  logic [63:0] r_data;
  logic [7:0]  r_keep;
  logic        r_last;
  logic        r_valid;
  logic        w_load;

  // Accept a new beat whenever the held one is gone or leaves this cycle.
  assign o_s_tready = ~r_valid | i_m_tready;
  assign w_load     = i_s_tvalid & o_s_tready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= i_s_tdata;
      r_keep  <= i_s_tkeep;
      r_last  <= i_s_tlast;
      r_valid <= 1'b1;
    end else if (i_m_tready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_m_tdata  = r_data;
  assign o_m_tkeep  = r_keep;
  assign o_m_tlast  = r_last;
  assign o_m_tvalid = r_valid;

endmodule

// File: rtl/us_ip_rx_mode.sv
// Routes received IP payload frames to the UDP or ICMP sink by protocol, dropping and
// counting frames of any other protocol.
module us_ip_rx_mode
  import us_ip_pkg::*;
#(
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                  rx_axis_aclk,
  input  logic                  rx_axis_areset,
  input  logic [63:0]           ip_rx_axis_tdata,
  input  logic [7:0]            ip_rx_axis_tkeep,
  input  logic                  ip_rx_axis_tvalid,
  input  logic                  ip_rx_axis_tlast,
  output logic                  ip_rx_axis_tready,
  input  logic [7:0]            ip_recv_type,
  input  logic                  ip_type_valid,
  output logic [63:0]           udp_rx_axis_tdata,
  output logic [7:0]            udp_rx_axis_tkeep,
  output logic                  udp_rx_axis_tvalid,
  output logic                  udp_rx_axis_tlast,
  input  logic                  udp_rx_axis_tready,
  output logic [63:0]           icmp_rx_axis_tdata,
  output logic [7:0]            icmp_rx_axis_tkeep,
  output logic                  icmp_rx_axis_tvalid,
  output logic                  icmp_rx_axis_tlast,
  input  logic                  icmp_rx_axis_tready,
  output logic                  recv_ip_end,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  rx_state_e             r_state;
  rx_state_e             w_state_d;
  logic                  r_sel_icmp;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic        w_forwarding;
  logic        w_slice_s_tready;
  logic        w_slice_s_tvalid;
  logic [63:0] w_out_data;
  logic [7:0]  w_out_keep;
  logic        w_out_last;
  logic        w_out_valid;
  logic        w_sel_tready;
  logic        w_in_hs;
  logic        w_drop_end;

  assign w_forwarding     = (r_state == RX_UDP) || (r_state == RX_ICMP);
  assign w_slice_s_tvalid = ip_rx_axis_tvalid & w_forwarding;
  // The select outlives the frame's input side so the last beat can drain from IDLE.
  assign w_sel_tready     = r_sel_icmp ? icmp_rx_axis_tready : udp_rx_axis_tready;

  assign ip_rx_axis_tready = ~rx_axis_areset &
                             ((r_state == RX_DROP) | (w_forwarding & w_slice_s_tready));
  assign w_in_hs           = ip_rx_axis_tvalid & ip_rx_axis_tready;
  assign w_drop_end        = (r_state == RX_DROP) & w_in_hs & ip_rx_axis_tlast;

  us_axis_reg_slice u_out_reg (
    .i_clk      (rx_axis_aclk),
    .i_rst      (rx_axis_areset),
    .i_s_tdata  (ip_rx_axis_tdata),
    .i_s_tkeep  (ip_rx_axis_tkeep),
    .i_s_tlast  (ip_rx_axis_tlast),
    .i_s_tvalid (w_slice_s_tvalid),
    .o_s_tready (w_slice_s_tready),
    .o_m_tdata  (w_out_data),
    .o_m_tkeep  (w_out_keep),
    .o_m_tlast  (w_out_last),
    .o_m_tvalid (w_out_valid),
    .i_m_tready (w_sel_tready)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      RX_IDLE: begin
        // Wait for the previous frame's last beat to leave before re-routing.
        if (ip_type_valid && !w_out_valid) begin
          if (ip_recv_type == IP_PROTO_UDP) begin
            w_state_d = RX_UDP;
          end else if (ip_recv_type == IP_PROTO_ICMP) begin
            w_state_d = RX_ICMP;
          end else begin
            w_state_d = RX_DROP;
          end
        end
      end
      RX_UDP, RX_ICMP, RX_DROP: begin
        if (w_in_hs && ip_rx_axis_tlast) begin
          w_state_d = RX_IDLE;
        end
      end
      default: w_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge rx_axis_aclk) begin
    if (rx_axis_areset) begin
      r_state    <= RX_IDLE;
      r_sel_icmp <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == RX_IDLE && w_state_d == RX_ICMP) begin
        r_sel_icmp <= 1'b1;
      end else if (r_state == RX_IDLE && w_state_d == RX_UDP) begin
        r_sel_icmp <= 1'b0;
      end
      if (w_drop_end && !(&r_drop_cnt)) begin
        r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

  assign udp_rx_axis_tdata   = w_out_data;
  assign udp_rx_axis_tkeep   = w_out_keep;
  assign udp_rx_axis_tlast   = w_out_last;
  assign udp_rx_axis_tvalid  = w_out_valid & ~r_sel_icmp;
  assign icmp_rx_axis_tdata  = w_out_data;
  assign icmp_rx_axis_tkeep  = w_out_keep;
  assign icmp_rx_axis_tlast  = w_out_last;
  assign icmp_rx_axis_tvalid = w_out_valid & r_sel_icmp;

  assign recv_ip_end = ~rx_axis_areset &
                       ((w_out_valid & w_sel_tready & w_out_last) | w_drop_end);
  assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_us_ip_rx_mode.sv
// Directed bench for us_ip_rx_mode: routing, latency, stalls, drop counting and reset.
module tb_us_ip_rx_mode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] ip_tdata = '0;
  logic [7:0]  ip_tkeep = '0;
  logic        ip_tvalid = 1'b0;
  logic        ip_tlast = 1'b0;
  logic        ip_tready;
  logic [7:0]  ip_type = '0;
  logic        ip_type_valid = 1'b0;
  logic [63:0] udp_tdata, icmp_tdata;
  logic [7:0]  udp_tkeep, icmp_tkeep;
  logic        udp_tvalid, udp_tlast, icmp_tvalid, icmp_tlast;
  logic        udp_ready = 1'b1;
  logic        icmp_ready = 1'b1;
  logic        recv_end;
  logic [15:0] drop_cnt;

  logic        s_ip_tready;
  logic [63:0] s_udp_tdata, s_icmp_tdata;
  logic [7:0]  s_udp_tkeep, s_icmp_tkeep;
  logic        s_udp_tvalid, s_udp_tlast, s_icmp_tvalid, s_icmp_tlast;
  logic        s_recv_end;
  logic [1:0]  s_drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  us_ip_rx_mode dut (
    .rx_axis_aclk        (clk),
    .rx_axis_areset      (rst),
    .ip_rx_axis_tdata    (ip_tdata),
    .ip_rx_axis_tkeep    (ip_tkeep),
    .ip_rx_axis_tvalid   (ip_tvalid),
    .ip_rx_axis_tlast    (ip_tlast),
    .ip_rx_axis_tready   (ip_tready),
    .ip_recv_type        (ip_type),
    .ip_type_valid       (ip_type_valid),
    .udp_rx_axis_tdata   (udp_tdata),
    .udp_rx_axis_tkeep   (udp_tkeep),
    .udp_rx_axis_tvalid  (udp_tvalid),
    .udp_rx_axis_tlast   (udp_tlast),
    .udp_rx_axis_tready  (udp_ready),
    .icmp_rx_axis_tdata  (icmp_tdata),
    .icmp_rx_axis_tkeep  (icmp_tkeep),
    .icmp_rx_axis_tvalid (icmp_tvalid),
    .icmp_rx_axis_tlast  (icmp_tlast),
    .icmp_rx_axis_tready (icmp_ready),
    .recv_ip_end         (recv_end),
    .drop_cnt            (drop_cnt)
  );

  us_ip_rx_mode #(.DROP_CNT_W(2)) dut_sat (
    .rx_axis_aclk        (clk),
    .rx_axis_areset      (rst),
    .ip_rx_axis_tdata    (ip_tdata),
    .ip_rx_axis_tkeep    (ip_tkeep),
    .ip_rx_axis_tvalid   (ip_tvalid),
    .ip_rx_axis_tlast    (ip_tlast),
    .ip_rx_axis_tready   (s_ip_tready),
    .ip_recv_type        (ip_type),
    .ip_type_valid       (ip_type_valid),
    .udp_rx_axis_tdata   (s_udp_tdata),
    .udp_rx_axis_tkeep   (s_udp_tkeep),
    .udp_rx_axis_tvalid  (s_udp_tvalid),
    .udp_rx_axis_tlast   (s_udp_tlast),
    .udp_rx_axis_tready  (udp_ready),
    .icmp_rx_axis_tdata  (s_icmp_tdata),
    .icmp_rx_axis_tkeep  (s_icmp_tkeep),
    .icmp_rx_axis_tvalid (s_icmp_tvalid),
    .icmp_rx_axis_tlast  (s_icmp_tlast),
    .icmp_rx_axis_tready (icmp_ready),
    .recv_ip_end         (s_recv_end),
    .drop_cnt            (s_drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] d, input logic [7:0] k, input logic l);
    ip_tvalid = 1'b1;
    ip_tdata  = d;
    ip_tkeep  = k;
    ip_tlast  = l;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if ({ip_tready, udp_tvalid, udp_tlast, icmp_tvalid, icmp_tlast, recv_end} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {ip_tready, udp_tvalid, udp_tlast, icmp_tvalid, icmp_tlast, recv_end});
    end
    checks++;
    if (udp_tdata !== 64'h0 || icmp_tdata !== 64'h0 || udp_tkeep !== 8'h0 ||
        icmp_tkeep !== 8'h0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h required 0/0", udp_tdata, udp_tkeep);
    end
    checks++;
    if (drop_cnt !== 16'd0 || s_drop_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_drop_cnt: got %0d/%0d required 0/0", drop_cnt, s_drop_cnt);
    end
    checks++;
    if ({s_ip_tready, s_udp_tvalid, s_icmp_tvalid, s_recv_end, s_udp_tlast, s_icmp_tlast}
        !== 6'b0 || (s_udp_tdata | s_icmp_tdata) !== 64'h0 ||
        (s_udp_tkeep | s_icmp_tkeep) !== 8'h0) begin
      errors++;
      $display("FAIL reset_sat_inst: got %b required 000000",
               {s_ip_tready, s_udp_tvalid, s_icmp_tvalid, s_recv_end});
    end
    rst = 1'b0;
    drive(64'hdead, 8'hff, 1'b0);
    #1;
    checks++;
    if (ip_tready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle_tready: got %b required 0", ip_tready);
    end
    tick();
    ip_tvalid = 1'b0;
  endtask

  task automatic test_udp();
    int ends = 0;
    udp_ready = 1'b1;
    icmp_ready = 1'b1;
    ip_type = 8'h11;
    ip_type_valid = 1'b1;
    drive(64'h1, 8'hff, 1'b0);
    #1;
    checks++;
    if (ip_tready !== 1'b0) begin
      errors++;
      $display("FAIL udp_idle_tready: got %b required 0", ip_tready);
    end
    tick();
    for (int i = 1; i <= 4; i++) begin
      drive(64'(i), 8'hff, i == 4);
      #1;
      checks++;
      if (ip_tready !== 1'b1) begin
        errors++;
        $display("FAIL udp_in_tready beat %0d: got %b required 1", i, ip_tready);
      end
      checks++;
      if (i == 1) begin
        if (udp_tvalid !== 1'b0) begin
          errors++;
          $display("FAIL udp_latency beat 1: got tvalid %b required 0", udp_tvalid);
        end
      end else if (udp_tvalid !== 1'b1 || udp_tdata !== 64'(i - 1) || udp_tlast !== 1'b0) begin
        errors++;
        $display("FAIL udp_out beat %0d: got %b/%h required 1/%h", i - 1, udp_tvalid,
                 udp_tdata, 64'(i - 1));
      end
      checks++;
      if (icmp_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL udp_icmp_quiet: got %b required 0", icmp_tvalid);
      end
      if (recv_end) ends++;
      tick();
      ip_type_valid = 1'b0;
    end
    ip_tvalid = 1'b0;
    #1;
    checks++;
    if (udp_tvalid !== 1'b1 || udp_tdata !== 64'h4 || udp_tlast !== 1'b1 || recv_end !== 1'b1)
    begin
      errors++;
      $display("FAIL udp_last: got %b/%h/%b/%b required 1/4/1/1", udp_tvalid, udp_tdata,
               udp_tlast, recv_end);
    end
    if (recv_end) ends++;
    tick();
    checks++;
    if (udp_tvalid !== 1'b0 || ip_tready !== 1'b0 || ends != 1) begin
      errors++;
      $display("FAIL udp_done: got tvalid %b tready %b ends %0d required 0 0 1", udp_tvalid,
               ip_tready, ends);
    end
  endtask

  task automatic test_icmp_stall();
    int in_idx = 1;
    int exp = 1;
    int ends = 0;
    logic stalled = 1'b0;
    logic [63:0] held = '0;
    ip_type = 8'h01;
    ip_type_valid = 1'b1;
    drive(64'h101, 8'hff, 1'b0);
    tick();
    for (int c = 0; c < 40 && exp <= 3; c++) begin
      icmp_ready = c[0];
      if (in_idx <= 3) drive(64'h100 + 64'(in_idx), (in_idx == 2) ? 8'h00 : 8'hff, in_idx == 3);
      else ip_tvalid = 1'b0;
      #1;
      if (icmp_tvalid) begin
        checks++;
        if (icmp_tdata !== 64'h100 + 64'(exp) || icmp_tkeep !== ((exp == 2) ? 8'h00 : 8'hff) ||
            icmp_tlast !== (exp == 3)) begin
          errors++;
          $display("FAIL icmp_beat %0d: got %h/%h/%b", exp, icmp_tdata, icmp_tkeep, icmp_tlast);
        end
      end
      if (stalled) begin
        checks++;
        if (icmp_tvalid !== 1'b1 || icmp_tdata !== held) begin
          errors++;
          $display("FAIL icmp_stall_stable: got %b/%h required 1/%h", icmp_tvalid, icmp_tdata,
                   held);
        end
      end
      checks++;
      if (udp_tvalid !== 1'b0) begin
        errors++;
        $display("FAIL icmp_udp_quiet: got %b required 0", udp_tvalid);
      end
      if (recv_end) ends++;
      stalled = icmp_tvalid & ~icmp_ready;
      held = icmp_tdata;
      if (icmp_tvalid && icmp_ready) exp++;
      if (ip_tvalid && ip_tready) begin
        in_idx++;
        ip_type_valid = 1'b0;
      end
      tick();
    end
    icmp_ready = 1'b1;
    ip_tvalid = 1'b0;
    checks++;
    if (exp != 4 || ends != 1) begin
      errors++;
      $display("FAIL icmp_complete: got delivered %0d ends %0d required 3 1", exp - 1, ends);
    end
  endtask

  task automatic test_drop();
    ip_type = 8'h06;
    ip_type_valid = 1'b1;
    drive(64'h601, 8'hff, 1'b0);
    tick();
    for (int i = 1; i <= 5; i++) begin
      drive(64'h600 + 64'(i), 8'hff, i == 5);
      #1;
      checks++;
      if (ip_tready !== 1'b1 || udp_tvalid !== 1'b0 || icmp_tvalid !== 1'b0 ||
          recv_end !== (i == 5)) begin
        errors++;
        $display("FAIL drop_beat %0d: got rdy %b uv %b iv %b end %b", i, ip_tready, udp_tvalid,
                 icmp_tvalid, recv_end);
      end
      tick();
      ip_type_valid = 1'b0;
    end
    ip_tvalid = 1'b0;
    #1;
    checks++;
    if (drop_cnt !== 16'd1 || s_drop_cnt !== 2'd1 || udp_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL drop_cnt: got %0d/%0d required 1/1", drop_cnt, s_drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    udp_ready = 1'b1;
    ip_type = 8'h11;
    ip_type_valid = 1'b1;
    drive(64'h201, 8'hff, 1'b0);
    tick();
    tick();
    ip_type_valid = 1'b0;
    drive(64'h202, 8'hff, 1'b1);
    tick();
    udp_ready = 1'b0;
    ip_type = 8'h01;
    ip_type_valid = 1'b1;
    drive(64'h301, 8'h0f, 1'b1);
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (ip_tready !== 1'b0 || udp_tvalid !== 1'b1 || udp_tdata !== 64'h202 ||
          udp_tlast !== 1'b1 || icmp_tvalid !== 1'b0 || recv_end !== 1'b0) begin
        errors++;
        $display("FAIL b2b_hold cycle %0d: got rdy %b uv %b ud %h iv %b end %b", c, ip_tready,
                 udp_tvalid, udp_tdata, icmp_tvalid, recv_end);
      end
      tick();
    end
    udp_ready = 1'b1;
    #1;
    checks++;
    if (recv_end !== 1'b1 || ip_tready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_udp_end: got end %b rdy %b required 1 0", recv_end, ip_tready);
    end
    tick();
    checks++;
    if (udp_tvalid !== 1'b0 || icmp_tvalid !== 1'b0 || ip_tready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: got uv %b iv %b rdy %b required 0 0 0", udp_tvalid, icmp_tvalid,
               ip_tready);
    end
    tick();
    checks++;
    if (ip_tready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_icmp_route: got rdy %b required 1", ip_tready);
    end
    tick();
    ip_type_valid = 1'b0;
    ip_tvalid = 1'b0;
    #1;
    checks++;
    if (icmp_tvalid !== 1'b1 || icmp_tdata !== 64'h301 || icmp_tkeep !== 8'h0f ||
        icmp_tlast !== 1'b1 || recv_end !== 1'b1 || udp_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_icmp_single: got iv %b d %h k %h end %b", icmp_tvalid, icmp_tdata,
               icmp_tkeep, recv_end);
    end
    tick();
    checks++;
    if (icmp_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_icmp_drained: got %b required 0", icmp_tvalid);
    end
  endtask

  task automatic test_reset_mid_frame();
    ip_type = 8'h11;
    ip_type_valid = 1'b1;
    drive(64'h401, 8'hff, 1'b0);
    tick();
    tick();
    ip_type_valid = 1'b0;
    drive(64'h402, 8'hff, 1'b0);
    rst = 1'b1;
    tick();
    #1;
    checks++;
    if ({ip_tready, udp_tvalid, udp_tlast, icmp_tvalid, recv_end} !== 5'b0 ||
        udp_tdata !== 64'h0 || udp_tkeep !== 8'h0 || drop_cnt !== 16'd0 ||
        s_drop_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: got rdy %b uv %b ud %h cnt %0d/%0d", ip_tready, udp_tvalid,
               udp_tdata, drop_cnt, s_drop_cnt);
    end
    rst = 1'b0;
    drive(64'h403, 8'hff, 1'b0);
    #1;
    checks++;
    if (ip_tready !== 1'b0 || recv_end !== 1'b0 || udp_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: got rdy %b end %b uv %b required 0 0 0", ip_tready,
               recv_end, udp_tvalid);
    end
    tick();
    ip_tvalid = 1'b0;
  endtask

  task automatic test_drop_saturate();
    logic [1:0] exp_sat;
    for (int f = 1; f <= 5; f++) begin
      ip_type = 8'h2a;
      ip_type_valid = 1'b1;
      drive(64'h500 + 64'(f), 8'hff, 1'b1);
      tick();
      tick();
      ip_type_valid = 1'b0;
      ip_tvalid = 1'b0;
      #1;
      exp_sat = (f >= 3) ? 2'd3 : 2'(f);
      checks++;
      if (drop_cnt !== 16'(f) || s_drop_cnt !== exp_sat) begin
        errors++;
        $display("FAIL drop_saturate frame %0d: got %0d/%0d required %0d/%0d", f, drop_cnt,
                 s_drop_cnt, f, exp_sat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_udp();
    test_icmp_stall();
    test_drop();
    test_back_to_back();
    test_reset_mid_frame();
    test_drop_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
